// File: rtl/liangdu_pkg.sv
// liangdu_pkg: shared widths, the counter wrap point and the level-to-duty
// expansion for the brightness PWM stage.
package liangdu_pkg;

   localparam int unsigned LEVEL_W = 4;
   localparam int unsigned DUTY_W  = 8;
   localparam logic [7:0]  CNT_MAX = 8'd254;

   // Repeating the 4-bit level in both nibbles equals level*17, mapping
   // 0..15 onto 0..255 with full scale reachable.
   function automatic logic [DUTY_W-1:0] level2duty(input logic [LEVEL_W-1:0] level);
      return {level, level};
   endfunction

endpackage

// File: rtl/liangdu_pwm_tick_gen.sv
// tick_gen: PWM tick prescaler.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   tick - high for one clk when the prescaler sits at TICK_DIV-1
//          (constantly high when TICK_DIV is 1)
module tick_gen #(
   parameter logic [15:0] TICK_DIV = 16'd195
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [15:0] pre;

   assign tick = (pre == TICK_DIV - 16'd1);

   always_ff @(posedge clk) begin
      if (rst)       pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + 16'd1;
   end

endmodule

// File: rtl/liangdu_pwm.sv
// liangdu_pwm: brightness PWM stage with slew-limited duty.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   num     - 4-bit level from the encoder block, asynchronous to clk
//   en      - output enable; low forces pwm_out low
//   pwm_out - registered PWM output, high for duty ticks per 255-tick period
//   duty    - currently applied duty (0..255)
//   busy    - high while duty differs from the target duty
//
// Handshakes: none. num is a level, qualified internally; there is no
// valid/ready pair on this block.
module liangdu_pwm
   import liangdu_pkg::*;
#(
   parameter logic [15:0] TICK_DIV = 16'd195,
   parameter logic [7:0]  STEP     = 8'd17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LEVEL_W-1:0] num,
   input  logic               en,
   output logic               pwm_out,
   output logic [DUTY_W-1:0]  duty,
   output logic               busy
);

   logic               tick;
   logic [LEVEL_W-1:0] s1, s2, s3;
   logic [DUTY_W-1:0]  target, target_next, duty_next;
   logic [7:0]         cnt;
   logic               boundary;
   logic [8:0]         diff, mag;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      target_next = target;
      duty_next   = duty;
      boundary    = tick && (cnt == CNT_MAX);
      // 9-bit two's-complement difference; bit 8 set means ramp down.
      diff        = {1'b0, target} - {1'b0, duty};
      mag         = diff[8] ? (9'd0 - diff) : diff;

      // Only load once the synchronised level has been stable for two
      // samples, so a single-cycle glitch cannot move the target.
      if (s2 == s3) target_next = level2duty(s3);

      // Slew uses the pre-load target; duty only moves at the period edge
      // so the output never shows a runt pulse.
      if (boundary) begin
         if (mag <= {1'b0, STEP}) duty_next = target;
         else if (diff[8])        duty_next = duty - STEP;
         else                     duty_next = duty + STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         s3      <= '0;
         target  <= '0;
         cnt     <= '0;
         duty    <= '0;
         busy    <= 1'b0;
         pwm_out <= 1'b0;
      end else begin
         s1      <= num;
         s2      <= s1;
         s3      <= s2;
         target  <= target_next;
         if (tick) cnt <= (cnt == CNT_MAX) ? 8'd0 : cnt + 8'd1;
         duty    <= duty_next;
         busy    <= (duty_next != target_next);
         pwm_out <= en && (cnt < duty);
      end
   end

endmodule
